// File: rtl/nx_sched_pkg.sv
// Shared types and defaults for the nx_token_sched mesh cycle scheduler.
package nx_sched_pkg;

    typedef enum logic [1:0] {
        StStopped,
        StBlank,
        StWaitQuiet,
        StTrigger
    } nx_sched_state_t;

    localparam int unsigned IdleSettleDefault  = 4;
    localparam int unsigned BlankCyclesDefault = 2;

    function automatic int unsigned nx_ptr_width(int unsigned columns);
        return (columns > 1) ? $clog2(columns) : 1;
    endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module nx_rr_arbiter
    import nx_sched_pkg::*;
#(
    parameter int unsigned COLUMNS = 3,
    parameter int unsigned PtrW    = nx_ptr_width(COLUMNS)
) (
    input  logic [COLUMNS-1:0] req_i,
    input  logic [PtrW-1:0]    ptr_i,
    input  logic               en_i,
    output logic [COLUMNS-1:0] grant_o,
    output logic [PtrW-1:0]    next_ptr_o
);

    always_comb begin
        int idx;
        idx        = 0;
        grant_o    = '0;
        next_ptr_o = ptr_i;
        if (en_i) begin
            // Walk offsets from farthest to nearest so the nearest requester wins.
            for (int off = int'(COLUMNS) - 1; off >= 0; off--) begin
                idx = (int'(ptr_i) + off) % int'(COLUMNS);
                if (req_i[PtrW'(idx)]) begin
                    grant_o             = '0;
                    grant_o[PtrW'(idx)] = 1'b1;
                    next_ptr_o          = (idx == int'(COLUMNS) - 1) ? '0 : PtrW'(idx + 1);
                end
            end
        end
    end

endmodule

// File: rtl/nx_token_sched.sv
// Mesh cycle sequencer and outbound-token arbiter.
// Optional grant-hold timeout is built when NX_TOKEN_TIMEOUT_EN is defined.
module nx_token_sched
    import nx_sched_pkg::*;
#(
    parameter int unsigned COLUMNS      = 3,
    parameter int unsigned IDLE_SETTLE  = IdleSettleDefault,
    parameter int unsigned BLANK_CYCLES = BlankCyclesDefault,
    parameter int unsigned CYCLE_WIDTH  = 32,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [CYCLE_WIDTH-1:0] cycle_limit_i,
    input  logic                   mesh_idle_i,
    output logic                   trigger_o,
    input  logic [COLUMNS-1:0]     token_req_i,
    output logic [COLUMNS-1:0]     token_grant_o,
    input  logic [COLUMNS-1:0]     token_release_i,
    output logic [CYCLE_WIDTH-1:0] cycle_count_o,
    output logic                   active_o,
    output logic                   idle_o,
    output logic                   timeout_o
);

    localparam int unsigned PtrW    = nx_ptr_width(COLUMNS);
    localparam int unsigned SettleW = $clog2(IDLE_SETTLE + 1);
    localparam int unsigned BlankW  = $clog2(BLANK_CYCLES + 1);

    nx_sched_state_t        state_q, state_d;
    logic [COLUMNS-1:0]     grant_q, grant_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [BlankW-1:0]      blank_q, blank_d;
    logic [SettleW-1:0]     settle_q, settle_d;
    logic [CYCLE_WIDTH-1:0] count_q, count_d;

    logic [COLUMNS-1:0] arb_grant;
    logic [PtrW-1:0]    arb_next_ptr;
    logic               arb_en, release_hit, hold_expired, grant_drop, busy_next, quiet;

    assign release_hit = |(token_release_i & grant_q);
    assign grant_drop  = release_hit | hold_expired;
    assign busy_next   = (grant_q != '0) && !grant_drop;
    assign quiet       = (token_req_i == '0) && (grant_q == '0) && mesh_idle_i;
    assign arb_en      = enable_i && (grant_q == '0) &&
                         ((state_q == StBlank) || (state_q == StWaitQuiet));

    nx_rr_arbiter #(
        .COLUMNS (COLUMNS),
        .PtrW    (PtrW)
    ) u_arb (
        .req_i      (token_req_i),
        .ptr_i      (ptr_q),
        .en_i       (arb_en),
        .grant_o    (arb_grant),
        .next_ptr_o (arb_next_ptr)
    );

`ifdef NX_TOKEN_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(TIMEOUT + 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    assign hold_expired = (grant_q != '0) && (hold_q == HoldW'(TIMEOUT - 1));

    always_comb begin
        hold_d    = '0;
        timeout_d = timeout_q | hold_expired;
        if ((grant_q != '0) && !release_hit && !hold_expired) begin
            hold_d = hold_q + HoldW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        blank_d  = blank_q;
        settle_d = '0;
        count_d  = count_q;

        if (grant_q != '0) begin
            if (grant_drop) grant_d = '0;
        end else if (arb_en) begin
            grant_d = arb_grant;
            ptr_d   = arb_next_ptr;
        end

        unique case (state_q)
            StStopped: begin
                blank_d = '0;
                if (enable_i && ((cycle_limit_i == '0) || (count_q < cycle_limit_i))) begin
                    state_d = StBlank;
                end
            end
            StBlank: begin
                // With enable low we only drain the outstanding grant.
                if (!enable_i) begin
                    if (!busy_next) state_d = StStopped;
                end else if (blank_q == BlankW'(BLANK_CYCLES - 1)) begin
                    blank_d = '0;
                    state_d = StWaitQuiet;
                end else begin
                    blank_d = blank_q + BlankW'(1);
                end
            end
            StWaitQuiet: begin
                if (!enable_i) begin
                    if (!busy_next) state_d = StStopped;
                end else if (quiet) begin
                    if (settle_q == SettleW'(IDLE_SETTLE - 1)) begin
                        state_d = StTrigger;
                    end else begin
                        settle_d = settle_q + SettleW'(1);
                    end
                end
            end
            StTrigger: begin
                count_d = count_q + CYCLE_WIDTH'(1);
                if (!enable_i || ((cycle_limit_i != '0) && (count_d == cycle_limit_i))) begin
                    state_d = StStopped;
                end else begin
                    state_d = StBlank;
                end
            end
            default: state_d = StStopped;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StStopped;
            grant_q  <= '0;
            ptr_q    <= '0;
            blank_q  <= '0;
            settle_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            blank_q  <= blank_d;
            settle_q <= settle_d;
            count_q  <= count_d;
        end
    end

    assign trigger_o     = (state_q == StTrigger);
    assign token_grant_o = grant_q;
    assign cycle_count_o = count_q;
    assign active_o      = (state_q != StStopped);
    assign idle_o        = (state_q == StWaitQuiet) && (settle_q != '0);

endmodule

// File: tb/tb_nx_token_sched.sv
// Scoreboard bench for nx_token_sched; honours NX_TOKEN_TIMEOUT_EN like the RTL.
module tb_nx_token_sched;

    localparam int C     = 3;
    localparam int CW    = 32;
    localparam int IDLE  = 4;
    localparam int BLANK = 2;
    localparam int TMO   = 8;
    localparam int NEVER = 1000000;
`ifdef NX_TOKEN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          mesh_idle = 1'b1;
    logic [CW-1:0] limit = '0;
    logic [C-1:0]  req = '0;
    logic [C-1:0]  rel = '0;
    logic          trig, active, idle_o, tmo_o;
    logic [C-1:0]  grant;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    nx_token_sched #(
        .COLUMNS      (C),
        .IDLE_SETTLE  (IDLE),
        .BLANK_CYCLES (BLANK),
        .CYCLE_WIDTH  (CW),
        .TIMEOUT      (TMO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .enable_i        (en),
        .cycle_limit_i   (limit),
        .mesh_idle_i     (mesh_idle),
        .trigger_o       (trig),
        .token_req_i     (req),
        .token_grant_o   (grant),
        .token_release_i (rel),
        .cycle_count_o   (count),
        .active_o        (active),
        .idle_o          (idle_o),
        .timeout_o       (tmo_o)
    );

    typedef struct {
        int cyc;
        longint val;
    } ev_t;

    ev_t q_grant[$];
    ev_t q_act[$];
    ev_t q_trig[$];
    int  g_hist[$];
    int  t_hist[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;

    // Behavioural model: phase flags plus remaining-duration counters.
    bit          m_run, m_fire, m_tmo;
    int          m_blank, m_quiet, m_holder = -1, m_hold, m_ptr, m_rel_at;
    int unsigned m_count;
    int          rel_fixed = 0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_extra(string name, longint act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output %0d, expected none (cycle %0d)", name, act, cyc);
    endtask

    function automatic longint gvec(int h);
        return (h < 0) ? 0 : (longint'(1) << h);
    endfunction

    function automatic int hist_at(int i);
        return (i < g_hist.size()) ? g_hist[i] : -1;
    endfunction

    task automatic model_step(bit rs, bit e, bit idl, logic [C-1:0] r, logic [C-1:0] rl,
                              int unsigned lim);
        longint old_g = gvec(m_holder);
        bit     old_a = m_run;
        int     nh, nhold;
        bit     found, expired;
        if (rs) begin
            m_run = 0; m_fire = 0; m_tmo = 0; m_blank = 0; m_quiet = 0;
            m_holder = -1; m_hold = 0; m_ptr = 0; m_count = 0;
        end else begin
            nh = m_holder;
            nhold = m_hold;
            if (m_holder >= 0) begin
                expired = TMO_EN && (m_hold == TMO);
                if (expired) m_tmo = 1;
                if (rl[m_holder] || expired) nh = -1;
                else nhold = m_hold + 1;
            end else if (m_run && !m_fire && e && r != 0) begin
                found = 0;
                for (int k = 0; k < C; k++) begin
                    int c = (m_ptr + k) % C;
                    if (!found && r[c]) begin
                        found = 1;
                        nh = c;
                        m_ptr = (c + 1) % C;
                        nhold = 1;
                        if (rel_fixed > 0) m_rel_at = rel_fixed;
                        else if (rel_fixed < 0) m_rel_at = NEVER;
                        else if (TMO_EN && $urandom_range(3) == 0) m_rel_at = NEVER;
                        else m_rel_at = $urandom_range(1, 4);
                    end
                end
            end
            if (!m_run) begin
                if (e && (lim == 0 || m_count < lim)) begin
                    m_run = 1; m_blank = BLANK; m_quiet = 0;
                end
            end else if (m_fire) begin
                m_fire = 0;
                m_count++;
                if (!e || (lim != 0 && m_count == lim)) m_run = 0;
                else m_blank = BLANK;
            end else if (!e) begin
                m_quiet = 0;
                if (nh < 0) m_run = 0;
            end else if (m_blank > 0) begin
                m_blank--;
            end else if (r == 0 && m_holder < 0 && idl) begin
                m_quiet++;
                if (m_quiet == IDLE) begin
                    m_fire = 1;
                    m_quiet = 0;
                end
            end else begin
                m_quiet = 0;
            end
            m_holder = nh;
            m_hold = nhold;
        end
        if (gvec(m_holder) != old_g) q_grant.push_back('{cyc + 1, gvec(m_holder)});
        if (m_run != old_a) q_act.push_back('{cyc + 1, longint'(m_run)});
        if (m_fire) q_trig.push_back('{cyc + 1, longint'(m_count)});
    endtask

    task automatic tick(bit rs, bit e, bit idl, logic [C-1:0] r, logic [C-1:0] xrel,
                        int unsigned lim);
        logic [C-1:0] rl;
        @(negedge clk);
        rl = xrel;
        if (m_holder >= 0 && m_hold == m_rel_at) rl[m_holder] = 1'b1;
        rst_n = !rs; en = e; mesh_idle = idl; req = r; rel = rl; limit = lim;
        model_step(rs, e, idl, r, rl, lim);
    endtask

    task automatic do_reset();
        repeat (2) tick(1, 0, 1, '0, '0, 0);
        g_hist.delete();
        t_hist.delete();
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every observed output event against the scoreboard queues.
    initial begin
        logic [C-1:0] pg = '0;
        bit           pa = 1'b0;
        ev_t          ev;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (grant !== pg) begin
                if (q_grant.size() == 0) fail_extra("grant_change", longint'(grant));
                else begin
                    ev = q_grant.pop_front();
                    check("grant_cycle", cyc, ev.cyc);
                    check("grant_value", longint'(grant), ev.val);
                end
                if (grant != '0) g_hist.push_back(int'(grant));
                pg = grant;
            end
            if (active !== pa) begin
                if (q_act.size() == 0) fail_extra("active_change", longint'(active));
                else begin
                    ev = q_act.pop_front();
                    check("active_cycle", cyc, ev.cyc);
                    check("active_value", longint'(active), ev.val);
                end
                pa = active;
            end
            if (trig === 1'b1) begin
                if (q_trig.size() == 0) fail_extra("trigger", longint'(count));
                else begin
                    ev = q_trig.pop_front();
                    check("trigger_cycle", cyc, ev.cyc);
                    check("trigger_count", longint'(count), ev.val);
                end
                t_hist.push_back(cyc);
            end
        end
    end

    initial begin
        int en_cyc, n;
        bit re;
        bit rs;
        logic [C-1:0] rq, xr;
        int unsigned lm;

        // Reset state
        repeat (3) tick(1, 1, 1, '0, '0, 0);
        sample();
        check("reset_trigger", trig, 0);
        check("reset_grant", grant, 0);
        check("reset_count", count, 0);
        check("reset_active", active, 0);
        check("reset_idle", idle_o, 0);
        check("reset_timeout", tmo_o, 0);
        g_hist.delete();
        t_hist.delete();

        // Quiet mesh: periodic triggers
        tick(0, 1, 1, '0, '0, 0);
        en_cyc = cyc;
        repeat (24) tick(0, 1, 1, '0, '0, 0);
        sample();
        check("first_trigger_delay", (t_hist.size() > 0) ? t_hist[0] - en_cyc : -1, 7);
        check("trigger_period", (t_hist.size() > 1) ? t_hist[1] - t_hist[0] : -1, 7);
        check("count_after_three", count, 3);

        // Round-robin with all columns requesting
        do_reset();
        rel_fixed = 2;
        repeat (20) tick(0, 1, 1, 3'b111, '0, 0);
        sample();
        check("rr_grant0", hist_at(0), 1);
        check("rr_grant1", hist_at(1), 2);
        check("rr_grant2", hist_at(2), 4);
        check("rr_grant3", hist_at(3), 1);
        check("rr_no_trigger", t_hist.size(), 0);

        // Pointer wrap, skip, and ignored foreign release
        do_reset();
        n = 0;
        while (m_holder != 1 && n < 12) begin
            tick(0, 1, 1, 3'b010, '0, 0);
            n++;
        end
        repeat (12) tick(0, 1, 1, 3'b011, 3'b100, 0);
        sample();
        check("wrap_grant0", hist_at(0), 2);
        check("wrap_grant1", hist_at(1), 1);
        check("wrap_grant2", hist_at(2), 2);

        // Cycle limit
        do_reset();
        repeat (40) tick(0, 1, 1, '0, '0, 3);
        sample();
        check("limit_triggers", t_hist.size(), 3);
        check("limit_count", count, 3);
        check("limit_active", active, 0);

        // Enable drop mid-grant
        do_reset();
        rel_fixed = -1;
        n = 0;
        while (m_holder != 1 && n < 12) begin
            tick(0, 1, 1, 3'b010, '0, 0);
            n++;
        end
        repeat (6) tick(0, 0, 1, 3'b111, '0, 0);
        sample();
        check("drain_active", active, 1);
        tick(0, 0, 1, 3'b111, 3'b010, 0);
        repeat (3) tick(0, 0, 1, 3'b111, '0, 0);
        sample();
        check("drain_stopped", active, 0);
        check("drain_grants", g_hist.size(), 1);
        check("drain_no_trigger", t_hist.size(), 0);

`ifdef NX_TOKEN_TIMEOUT_EN
        // Grant revoked by timeout
        do_reset();
        n = 0;
        while (m_holder != 0 && n < 12) begin
            tick(0, 1, 1, 3'b001, '0, 0);
            n++;
        end
        repeat (14) tick(0, 1, 1, 3'b011, '0, 0);
        sample();
        check("tmo_grant0", hist_at(0), 1);
        check("tmo_grant1", hist_at(1), 2);
        check("tmo_flag", tmo_o, 1);
        repeat (4) tick(0, 1, 1, '0, '0, 0);
        sample();
        check("tmo_sticky", tmo_o, 1);
`endif

        // Randomised traffic
        do_reset();
        rel_fixed = 0;
        re = 1;
        rq = '0;
        lm = 0;
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(399) == 0);
            if ($urandom_range(59) == 0) re = !re;
            if ($urandom_range(3) == 0) rq = ($urandom_range(1) == 0) ? 3'b000 : 3'($urandom);
            if (rs) lm = ($urandom_range(2) == 0) ? $urandom_range(1, 5) : 0;
            xr = ($urandom_range(9) == 0) ? 3'($urandom) : 3'b000;
            tick(rs, re, ($urandom_range(7) != 0), rq, xr, lm);
        end
        repeat (10) tick(0, re, 1, '0, '0, lm);
        sample();
        check("final_count", count, m_count);
        check("final_timeout", tmo_o, m_tmo);
        check("final_idle", idle_o, (m_run && !m_fire && m_blank == 0 && m_quiet > 0));
        check("grant_events_left", q_grant.size(), 0);
        check("active_events_left", q_act.size(), 0);
        check("trigger_events_left", q_trig.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
